// File: rtl/arbitro_calc.sv
// Two-requester arbitrated calculator: add, subtract (sign/magnitude), shift-add multiply, clear.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default build uses fixed priority to 0.
module arbitro_calc #(
   parameter int unsigned W = 7
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid0,
   input  logic            req_valid1,
   output logic            req_ready0,
   output logic            req_ready1,
   input  logic [1:0]      op0,
   input  logic [1:0]      op1,
   input  logic [W-1:0]    A0,
   input  logic [W-1:0]    B0,
   input  logic [W-1:0]    A1,
   input  logic [W-1:0]    B1,
   output logic            res_valid,
   input  logic            res_ready,
   output logic [2*W-1:0]  Y,
   output logic            sinal,
   output logic            res_id,
   output logic            busy
);

   localparam int unsigned RW = 2 * W;
   localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

   localparam logic [1:0] OpSoma  = 2'b00;
   localparam logic [1:0] OpSub   = 2'b01;
   localparam logic [1:0] OpMulti = 2'b10;

   typedef enum logic [1:0] {OCIOSO, EXEC, MULT, PRONTO} state_t;

   state_t          state_q, state_d;
   logic            grant0, grant1, accept;
   logic [1:0]      sel_op;
   logic [W-1:0]    sel_a, sel_b;

   logic [1:0]      op_q;
   logic [W-1:0]    a_q, b_q;
   logic            id_q;

   logic [RW-1:0]   acc_q, mcand_q, acc_sum;
   logic [W-1:0]    mplier_q;
   logic [CW-1:0]   cnt_q;
   logic            mult_last;

   logic [RW-1:0]   y_q, exec_y;
   logic            sinal_q, exec_neg;

`ifdef ARB_ROUND_ROBIN_EN
   // Set when requester 1 should win the next simultaneous request.
   logic            ptr_q;
`endif

   // Grants only exist in OCIOSO and never while reset is asserted.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (state_q == OCIOSO && !rst) begin
`ifdef ARB_ROUND_ROBIN_EN
         if (req_valid0 && req_valid1) begin
            grant0 = ~ptr_q;
            grant1 = ptr_q;
         end else begin
            grant0 = req_valid0;
            grant1 = req_valid1;
         end
`else
         grant0 = req_valid0;
         grant1 = req_valid1 & ~req_valid0;
`endif
      end
   end

   assign accept = grant0 | grant1;
   assign sel_op = grant1 ? op1 : op0;
   assign sel_a  = grant1 ? A1  : A0;
   assign sel_b  = grant1 ? B1  : B0;

   assign mult_last = (cnt_q == CW'(W - 1));

   always_comb begin
      state_d = state_q;
      case (state_q)
         OCIOSO: begin
            if (accept) begin
               state_d = (sel_op == OpMulti) ? MULT : EXEC;
            end
         end
         EXEC:    state_d = PRONTO;
         MULT:    if (mult_last) state_d = PRONTO;
         PRONTO:  if (res_ready) state_d = OCIOSO;
         default: state_d = OCIOSO;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= OCIOSO;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      exec_y   = '0;
      exec_neg = 1'b0;
      case (op_q)
         OpSoma: exec_y = RW'(a_q) + RW'(b_q);
         OpSub: begin
            if (b_q > a_q) begin
               exec_y   = RW'(b_q - a_q);
               exec_neg = 1'b1;
            end else begin
               exec_y = RW'(a_q - b_q);
            end
         end
         default: exec_y = '0;
      endcase
   end

   // One partial product per MULT cycle; the final one lands directly in y_q.
   assign acc_sum = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         id_q     <= 1'b0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         y_q      <= '0;
         sinal_q  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         ptr_q    <= 1'b0;
`endif
      end else begin
         case (state_q)
            OCIOSO: begin
               if (accept) begin
                  op_q     <= sel_op;
                  a_q      <= sel_a;
                  b_q      <= sel_b;
                  id_q     <= grant1;
                  acc_q    <= '0;
                  mcand_q  <= RW'(sel_a);
                  mplier_q <= sel_b;
                  cnt_q    <= '0;
`ifdef ARB_ROUND_ROBIN_EN
                  ptr_q    <= grant0;
`endif
               end
            end
            EXEC: begin
               y_q     <= exec_y;
               sinal_q <= exec_neg;
            end
            MULT: begin
               acc_q    <= acc_sum;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q + CW'(1);
               if (mult_last) begin
                  y_q     <= acc_sum;
                  sinal_q <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign req_ready0 = grant0;
   assign req_ready1 = grant1;
   assign res_valid  = (state_q == PRONTO);
   assign busy       = (state_q != OCIOSO);
   assign Y          = y_q;
   assign sinal      = sinal_q;
   assign res_id     = id_q;

endmodule

// File: doc/arbitro_calc.md
ARBITRO_CALC -- requirements
Module: arbitro_calc

Interface
REQ-001 The block SHALL have parameter W, default 7, operand width in bits; result width is 2*W.
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have ports req_valid0, req_valid1  input  1 each  requester 0/1 has a pending operation.
REQ-005 The block SHALL have ports req_ready0, req_ready1  output  1 each  operation from requester 0/1 accepted this cycle.
REQ-006 The block SHALL have ports op0, op1  input  2 each  operation: 00 soma, 01 sub, 10 multi, 11 limpa (clear).
REQ-007 The block SHALL have ports A0, B0, A1, B1  input  W each  unsigned operands per requester.
REQ-008 The block SHALL have port res_valid  output  1  Y/sinal/res_id hold a valid result.
REQ-009 The block SHALL have port res_ready  input  1  consumer takes the result.
REQ-010 The block SHALL have port Y  output  2*W  magnitude of result.
REQ-011 The block SHALL have port sinal  output  1  1 = result negative (sub only).
REQ-012 The block SHALL have port res_id  output  1  index of requester that owns the result.
REQ-013 The block SHALL have port busy  output  1  high in every state except OCIOSO.

Function
REQ-014 The FSM SHALL have states OCIOSO, EXEC, MULT, PRONTO.
REQ-015 In OCIOSO the arbiter SHALL grant exactly one requester with req_valid high by asserting its req_ready combinationally; at most one req_ready high per cycle; none in other states.
REQ-016 On an accept edge (req_validN and req_readyN high) the block SHALL register op, A, B, requester index, and go to EXEC (op 00/01/11) or MULT (op 10).
REQ-017 EXEC SHALL last one cycle: soma Y=A+B, sinal=0; sub: if B>A then Y=B-A, sinal=1, else Y=A-B, sinal=0; limpa Y=0, sinal=0; then PRONTO.
REQ-018 MULT SHALL compute Y=A*B by iterative shift-add over exactly W cycles, sinal=0, then PRONTO; no combinational W×W multiplier.
REQ-019 Latency from accept edge to first cycle with res_valid high SHALL be 2 cycles for soma/sub/limpa and W+1 cycles for multi.
REQ-020 In PRONTO res_valid SHALL be high and Y, sinal, res_id SHALL be stable until an edge with res_ready high, after which the FSM returns to OCIOSO.
REQ-021 res_ready while res_valid is low SHALL be ignored.
REQ-022 Requester inputs changing after the accept edge SHALL not affect the operation in flight.
REQ-023 Y SHALL not overflow: max soma 2*(2^W-1), max multi (2^W-1)^2, both within 2*W bits.

Reset
REQ-024 On a rising clk edge with rst high the FSM SHALL enter OCIOSO, Y=0, sinal=0, res_id=0, res_valid=0, busy=0, arbitration pointer to requester 0, regardless of state (including mid-MULT); any in-flight operation is discarded.
REQ-025 req_ready0/1 SHALL be low during any cycle with rst high.

Configuration
REQ-026 With macro ARB_ROUND_ROBIN_EN defined, on simultaneous requests the arbiter SHALL grant the requester not granted most recently (pointer toggles on each accept).
REQ-027 Without ARB_ROUND_ROBIN_EN, the arbiter SHALL use fixed priority: requester 0 always wins simultaneous requests.

Verification
REQ-028 Reset then req_valid0, op0=00, A0=100, B0=27 -> res_valid 2 cycles after accept, Y=127, sinal=0, res_id=0.
REQ-029 req_valid1, op1=01, A1=5, B1=20 -> Y=15, sinal=1, res_id=1; then A1=20, B1=20 -> Y=0, sinal=0.
REQ-030 op0=10, A0=127, B0=127 -> res_valid exactly 8 cycles after accept, Y=16129; res_ready held low 5 cycles -> Y stable, no new req_ready.
REQ-031 Both requesters valid continuously, op=11 -> with ARB_ROUND_ROBIN_EN res_id alternates 0,1,0,1; without it res_id always 0.
REQ-032 rst asserted in 3rd MULT cycle -> next cycle res_valid=0, Y=0, busy=0; new request accepted normally afterwards.
